// File: rtl/dcache_pkg.sv
// Shared types and sizing for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int unsigned ADDR_BITS  = 8;
    localparam int unsigned DATA_BITS  = 16;
    localparam int unsigned NUM_LINES  = 4;
    localparam int unsigned INDEX_BITS = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS   = ADDR_BITS - INDEX_BITS;
    localparam int unsigned COUNT_BITS = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_WAIT,
        S_READ_RELAY,
        S_WT_WAIT,
        S_WRITE_RELAY
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_BITS-1:0]  tag;
        logic [DATA_BITS-1:0] data;
    } line_t;

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] addr);
        return addr[INDEX_BITS-1:0];
    endfunction

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] addr);
        return addr[ADDR_BITS-1:INDEX_BITS];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: combinational lookup, one write port, synchronous flush of valid bits.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [ADDR_BITS-1:0] lookup_address,
    output logic                 hit_c,
    output logic [DATA_BITS-1:0] lookup_data_c,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_address,
    input  logic [DATA_BITS-1:0] wr_data
);

    line_t lines [NUM_LINES];
    line_t lookup_line_c;

    assign lookup_line_c = lines[addr_index(lookup_address)];
    assign hit_c         = lookup_line_c.valid && (lookup_line_c.tag == addr_tag(lookup_address));
    assign lookup_data_c = lookup_line_c.data;

    // Flush is applied after the write so a same-edge fill still ends up invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                lines[addr_index(wr_address)] <= '{valid: 1'b1,
                                                   tag:   addr_tag(wr_address),
                                                   data:  wr_data};
            end
            if (flush) begin
                for (int i = 0; i < NUM_LINES; i++) begin
                    lines[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-through, write-allocate data cache between the LSU and the memory controller.
// Optional load hit/miss statistics are built when DCACHE_STATS_EN is defined.
module dcache
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  lsu_read_valid,
    input  logic [ADDR_BITS-1:0]  lsu_read_address,
    output logic                  lsu_read_ready,
    output logic [DATA_BITS-1:0]  lsu_read_data,
    input  logic                  lsu_write_valid,
    input  logic [ADDR_BITS-1:0]  lsu_write_address,
    input  logic [DATA_BITS-1:0]  lsu_write_data,
    output logic                  lsu_write_ready,
    output logic                  ctrl_read_valid,
    output logic [ADDR_BITS-1:0]  ctrl_read_address,
    input  logic                  ctrl_read_ready,
    input  logic [DATA_BITS-1:0]  ctrl_read_data,
    output logic                  ctrl_write_valid,
    output logic [ADDR_BITS-1:0]  ctrl_write_address,
    output logic [DATA_BITS-1:0]  ctrl_write_data,
    input  logic                  ctrl_write_ready,
    output logic [COUNT_BITS-1:0] hit_count,
    output logic [COUNT_BITS-1:0] miss_count
);

    state_t state, state_nxt;

    logic                 hit_c;
    logic [DATA_BITS-1:0] lookup_data_c;
    logic                 wr_en_c;
    logic [ADDR_BITS-1:0] wr_address_c;
    logic [DATA_BITS-1:0] wr_data_c;

    logic                 lsu_read_ready_nxt;
    logic [DATA_BITS-1:0] lsu_read_data_nxt;
    logic                 lsu_write_ready_nxt;
    logic                 ctrl_read_valid_nxt;
    logic [ADDR_BITS-1:0] ctrl_read_address_nxt;
    logic                 ctrl_write_valid_nxt;
    logic [ADDR_BITS-1:0] ctrl_write_address_nxt;
    logic [DATA_BITS-1:0] ctrl_write_data_nxt;

    dcache_array u_array (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .lookup_address (lsu_read_address),
        .hit_c          (hit_c),
        .lookup_data_c  (lookup_data_c),
        .wr_en          (wr_en_c),
        .wr_address     (wr_address_c),
        .wr_data        (wr_data_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (lsu_read_valid) begin
                    state_nxt = hit_c ? S_READ_RELAY : S_FILL_WAIT;
                end else if (lsu_write_valid) begin
                    state_nxt = S_WT_WAIT;
                end
            end
            S_FILL_WAIT:   if (ctrl_read_ready)  state_nxt = S_READ_RELAY;
            S_WT_WAIT:     if (ctrl_write_ready) state_nxt = S_WRITE_RELAY;
            // Relays wait for both sides to release so a stale ready never answers the next request.
            S_READ_RELAY:  if (!lsu_read_valid && !ctrl_read_ready)   state_nxt = S_IDLE;
            S_WRITE_RELAY: if (!lsu_write_valid && !ctrl_write_ready) state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        lsu_read_ready_nxt     = lsu_read_ready;
        lsu_read_data_nxt      = lsu_read_data;
        lsu_write_ready_nxt    = lsu_write_ready;
        ctrl_read_valid_nxt    = ctrl_read_valid;
        ctrl_read_address_nxt  = ctrl_read_address;
        ctrl_write_valid_nxt   = ctrl_write_valid;
        ctrl_write_address_nxt = ctrl_write_address;
        ctrl_write_data_nxt    = ctrl_write_data;
        wr_en_c                = 1'b0;
        wr_address_c           = ctrl_read_address;
        wr_data_c              = ctrl_read_data;
        case (state)
            S_IDLE: begin
                if (lsu_read_valid) begin
                    if (hit_c) begin
                        lsu_read_data_nxt  = lookup_data_c;
                        lsu_read_ready_nxt = 1'b1;
                    end else begin
                        ctrl_read_valid_nxt   = 1'b1;
                        ctrl_read_address_nxt = lsu_read_address;
                    end
                end else if (lsu_write_valid) begin
                    ctrl_write_valid_nxt   = 1'b1;
                    ctrl_write_address_nxt = lsu_write_address;
                    ctrl_write_data_nxt    = lsu_write_data;
                end
            end
            S_FILL_WAIT: begin
                if (ctrl_read_ready) begin
                    ctrl_read_valid_nxt = 1'b0;
                    lsu_read_data_nxt   = ctrl_read_data;
                    lsu_read_ready_nxt  = 1'b1;
                    wr_en_c             = 1'b1;
                end
            end
            S_WT_WAIT: begin
                wr_address_c = ctrl_write_address;
                wr_data_c    = ctrl_write_data;
                if (ctrl_write_ready) begin
                    ctrl_write_valid_nxt = 1'b0;
                    lsu_write_ready_nxt  = 1'b1;
                    wr_en_c              = 1'b1;
                end
            end
            S_READ_RELAY: begin
                if (!lsu_read_valid && !ctrl_read_ready) lsu_read_ready_nxt = 1'b0;
            end
            S_WRITE_RELAY: begin
                if (!lsu_write_valid && !ctrl_write_ready) lsu_write_ready_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lsu_read_ready     <= 1'b0;
            lsu_read_data      <= '0;
            lsu_write_ready    <= 1'b0;
            ctrl_read_valid    <= 1'b0;
            ctrl_read_address  <= '0;
            ctrl_write_valid   <= 1'b0;
            ctrl_write_address <= '0;
            ctrl_write_data    <= '0;
        end else begin
            lsu_read_ready     <= lsu_read_ready_nxt;
            lsu_read_data      <= lsu_read_data_nxt;
            lsu_write_ready    <= lsu_write_ready_nxt;
            ctrl_read_valid    <= ctrl_read_valid_nxt;
            ctrl_read_address  <= ctrl_read_address_nxt;
            ctrl_write_valid   <= ctrl_write_valid_nxt;
            ctrl_write_address <= ctrl_write_address_nxt;
            ctrl_write_data    <= ctrl_write_data_nxt;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [COUNT_BITS-1:0] hit_q, miss_q;
    logic                  load_in_idle_c;

    assign load_in_idle_c = (state == S_IDLE) && lsu_read_valid;

    // Saturating load statistics, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (load_in_idle_c && hit_c && (hit_q != '1))   hit_q  <= hit_q + COUNT_BITS'(1);
            if (load_in_idle_c && !hit_c && (miss_q != '1)) miss_q <= miss_q + COUNT_BITS'(1);
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache with a transaction-level cache/memory model and a per-cycle handshake checker.
module tb_dcache;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        lsu_read_valid;
    logic [7:0]  lsu_read_address;
    logic        lsu_read_ready;
    logic [15:0] lsu_read_data;
    logic        lsu_write_valid;
    logic [7:0]  lsu_write_address;
    logic [15:0] lsu_write_data;
    logic        lsu_write_ready;
    logic        ctrl_read_valid;
    logic [7:0]  ctrl_read_address;
    logic        ctrl_read_ready;
    logic [15:0] ctrl_read_data;
    logic        ctrl_write_valid;
    logic [7:0]  ctrl_write_address;
    logic [15:0] ctrl_write_data;
    logic        ctrl_write_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    dcache dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .lsu_read_valid     (lsu_read_valid),
        .lsu_read_address   (lsu_read_address),
        .lsu_read_ready     (lsu_read_ready),
        .lsu_read_data      (lsu_read_data),
        .lsu_write_valid    (lsu_write_valid),
        .lsu_write_address  (lsu_write_address),
        .lsu_write_data     (lsu_write_data),
        .lsu_write_ready    (lsu_write_ready),
        .ctrl_read_valid    (ctrl_read_valid),
        .ctrl_read_address  (ctrl_read_address),
        .ctrl_read_ready    (ctrl_read_ready),
        .ctrl_read_data     (ctrl_read_data),
        .ctrl_write_valid   (ctrl_write_valid),
        .ctrl_write_address (ctrl_write_address),
        .ctrl_write_data    (ctrl_write_data),
        .ctrl_write_ready   (ctrl_write_ready),
        .hit_count          (hit_count),
        .miss_count         (miss_count)
    );

    always #5 clk = ~clk;

    // Model: backing memory, cache contents by index, expected handshake levels and counters.
    logic [15:0] mem [256];
    bit          m_valid [4];
    logic [5:0]  m_tag [4];
    logic [15:0] m_data [4];
    bit          exp_lrr, exp_lwr, exp_crv, exp_cwv;
    int          exp_hits, exp_misses;
    bit          cmp_en;
    int          n_checks, n_fail;

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset && cmp_en) begin
            check("lsu_read_ready",   32'(lsu_read_ready),   32'(exp_lrr));
            check("lsu_write_ready",  32'(lsu_write_ready),  32'(exp_lwr));
            check("ctrl_read_valid",  32'(ctrl_read_valid),  32'(exp_crv));
            check("ctrl_write_valid", 32'(ctrl_write_valid), 32'(exp_cwv));
            check("hit_count",        32'(hit_count),        32'(exp_hits));
            check("miss_count",       32'(miss_count),       32'(exp_misses));
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void count(input bit hit);
        if (STATS) begin
            if (hit) exp_hits   = (exp_hits   == 32'hFFFF) ? exp_hits   : exp_hits + 1;
            else     exp_misses = (exp_misses == 32'hFFFF) ? exp_misses : exp_misses + 1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] addr, input int delay, input bit linger,
                           input bit flush_at_fill, output bit was_hit);
        int idx;
        idx = int'(addr[1:0]);
        lsu_read_valid   = 1'b1;
        lsu_read_address = addr;
        step();
        was_hit = m_valid[idx] && (m_tag[idx] == addr[7:2]);
        count(was_hit);
        if (was_hit) begin
            exp_lrr = 1'b1;
            check("hit_data", 32'(lsu_read_data), 32'(m_data[idx]));
        end else begin
            exp_crv = 1'b1;
            check("fill_address", 32'(ctrl_read_address), 32'(addr));
            repeat (delay) step();
            ctrl_read_ready = 1'b1;
            ctrl_read_data  = mem[addr];
            flush           = flush_at_fill;
            step();
            exp_crv = 1'b0;
            exp_lrr = 1'b1;
            if (flush_at_fill) begin
                model_clear();
            end else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = addr[7:2];
                m_data[idx]  = mem[addr];
            end
            flush = 1'b0;
            check("fill_data", 32'(lsu_read_data), 32'(mem[addr]));
            ctrl_read_data = 16'hDEAD;
            if (!linger) ctrl_read_ready = 1'b0;
        end
        if (linger) begin
            step();
            ctrl_read_ready = 1'b0;
        end
        lsu_read_valid = 1'b0;
        step();
        exp_lrr = 1'b0;
    endtask

    task automatic do_store(input logic [7:0] addr, input logic [15:0] data, input int delay);
        int idx;
        idx = int'(addr[1:0]);
        lsu_write_valid   = 1'b1;
        lsu_write_address = addr;
        lsu_write_data    = data;
        step();
        exp_cwv = 1'b1;
        check("wt_address", 32'(ctrl_write_address), 32'(addr));
        check("wt_data",    32'(ctrl_write_data),    32'(data));
        repeat (delay) step();
        ctrl_write_ready = 1'b1;
        step();
        exp_cwv = 1'b0;
        exp_lwr = 1'b1;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = addr[7:2];
        m_data[idx]  = data;
        mem[addr]    = data;
        ctrl_write_ready = 1'b0;
        lsu_write_valid  = 1'b0;
        step();
        exp_lwr = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_clear();
    endtask

    initial begin
        bit h;
        n_checks = 0; n_fail = 0; cmp_en = 1'b0;
        exp_lrr = 0; exp_lwr = 0; exp_crv = 0; exp_cwv = 0;
        exp_hits = 0; exp_misses = 0;
        for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i)};
        mem[8'h05] = 16'h1234;
        model_clear();
        reset = 1'b0; flush = 1'b0;
        lsu_read_valid = 0; lsu_read_address = '0;
        lsu_write_valid = 0; lsu_write_address = '0; lsu_write_data = '0;
        ctrl_read_ready = 0; ctrl_read_data = '0; ctrl_write_ready = 0;
        #1;
        check("reset_outputs", {8'(lsu_read_ready), 8'(lsu_write_ready), 8'(ctrl_read_valid),
                                8'(ctrl_write_valid)}, 32'h0);
        check("reset_counts", {hit_count, miss_count}, 32'h0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        step();
        cmp_en = 1'b1;

        // Cold miss then hit.
        do_load(8'h05, 2, 1'b0, 1'b0, h);
        check("cold_miss", 32'(h), 32'h0);
        check("cold_data_literal", 32'(lsu_read_data), 32'h1234);
        check("cold_addr_literal", 32'(ctrl_read_address), 32'h05);
        do_load(8'h05, 0, 1'b1, 1'b0, h);
        check("repeat_hit", 32'(h), 32'h1);
        if (STATS) check("counts_after_hit", {hit_count, miss_count}, 32'h0001_0001);

        // Conflict on index 1.
        do_load(8'h09, 1, 1'b1, 1'b0, h);
        check("conflict_miss_09", 32'(h), 32'h0);
        do_load(8'h05, 0, 1'b0, 1'b0, h);
        check("conflict_miss_05", 32'(h), 32'h0);
        if (STATS) check("miss_count_3", 32'(miss_count), 32'd3);

        // Write-through with allocate.
        do_store(8'h05, 16'hBEEF, 1);
        check("wt_data_literal", 32'(ctrl_write_data), 32'hBEEF);
        do_load(8'h05, 0, 1'b0, 1'b0, h);
        check("store_then_hit", 32'(h), 32'h1);
        check("store_hit_literal", 32'(lsu_read_data), 32'hBEEF);

        // Flush, then flush coinciding with a fill.
        flush_pulse();
        do_load(8'h05, 0, 1'b0, 1'b1, h);
        check("flush_miss", 32'(h), 32'h0);
        check("flush_fill_data", 32'(lsu_read_data), 32'hBEEF);
        do_load(8'h05, 1, 1'b0, 1'b0, h);
        check("after_flush_fill_miss", 32'(h), 32'h0);

        // Simultaneous load and store: load first.
        lsu_write_valid = 1'b1; lsu_write_address = 8'h22; lsu_write_data = 16'h5A5A;
        do_load(8'h05, 0, 1'b0, 1'b0, h);
        check("simul_load_hit", 32'(h), 32'h1);
        do_store(8'h22, 16'h5A5A, 0);
        do_load(8'h22, 0, 1'b0, 1'b0, h);
        check("simul_store_hit", 32'(h), 32'h1);
        check("simul_store_data", 32'(lsu_read_data), 32'h5A5A);

        // Asynchronous reset during FILL_WAIT.
        lsu_read_valid = 1'b1; lsu_read_address = 8'h30;
        step();
        exp_crv = 1'b1;
        count(1'b0);
        check("pre_reset_fill", 32'(ctrl_read_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_outputs", {8'(lsu_read_ready), 8'(lsu_write_ready), 8'(ctrl_read_valid),
                                      8'(ctrl_write_valid)}, 32'h0);
        check("async_reset_addr", {lsu_read_data, 8'h0, ctrl_read_address}, 32'h0);
        check("async_reset_counts", {hit_count, miss_count}, 32'h0);
        exp_crv = 0; exp_lrr = 0; exp_hits = 0; exp_misses = 0;
        model_clear();
        lsu_read_valid = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        step();
        do_load(8'h22, 0, 1'b0, 1'b0, h);
        check("post_reset_miss", 32'(h), 32'h0);
        check("post_reset_data", 32'(lsu_read_data), 32'h5A5A);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
